// File: rtl/gmii_frame_tx_if.sv
// Byte-wide AXI-Stream channel from the TX FIFO
// into the GMII framer.
interface gmii_frame_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/gmii_frame_tx.sv
// GMII transmit framer: preamble/SFD, padding,
// CRC-32 FCS, inter-frame gap and underflow handling.
module gmii_frame_tx #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64
) (
  input  logic           tx_clk,
  input  logic           tx_rst,
  gmii_frame_tx_if.slave s_axis,
  output logic [7:0]     gmii_txd,
  output logic           gmii_tx_en,
  output logic           gmii_tx_er,
  input  logic [7:0]     ifg_delay,
  output logic           error_underflow
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, PAYLOAD, PAD,
    FCS, DISCARD, IFG
  } state_t;

  localparam logic [15:0] MIN_DATA =
    16'(MIN_FRAME_LENGTH - 4);
  localparam logic [7:0] IFG_MIN = 8'd12;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_inc;
  logic [7:0]  sub, ifg_len, ifg_sel;
  logic [31:0] crc;
  logic [7:0]  crc_in, txd_d;
  logic        crc_upd, en_d, er_d, unf_d;
  logic        pad_short;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320)
               : (r >> 1);
    return r;
  endfunction

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt
                                     : cnt + 16'd1;
  assign ifg_sel = (ifg_delay < IFG_MIN) ? IFG_MIN
                                         : ifg_delay;
  assign pad_short = (ENABLE_PADDING != 0) &&
                     (cnt_inc < MIN_DATA);

  assign s_axis.tready = (state == PAYLOAD) ||
                         (state == DISCARD);

  // State register
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (s_axis.tvalid) state_nxt = PREAMBLE;
      PREAMBLE:
        if (sub == 8'd6) state_nxt = PAYLOAD;
      PAYLOAD:
        if (!s_axis.tvalid) state_nxt = DISCARD;
        else if (s_axis.tlast) begin
          if (s_axis.tuser)   state_nxt = IFG;
          else if (pad_short) state_nxt = PAD;
          else                state_nxt = FCS;
        end
      PAD:
        if (cnt_inc >= MIN_DATA) state_nxt = FCS;
      FCS:
        if (sub == 8'd3) state_nxt = IFG;
      DISCARD:
        if (s_axis.tvalid && s_axis.tlast)
          state_nxt = IFG;
      IFG:
        if (sub == ifg_len - 8'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next GMII byte and CRC feed for this cycle
  always_comb begin
    txd_d   = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    unf_d   = 1'b0;
    crc_upd = 1'b0;
    crc_in  = s_axis.tdata;
    unique case (state)
      IDLE:
        if (s_axis.tvalid) begin
          txd_d = 8'h55;
          en_d  = 1'b1;
        end
      PREAMBLE: begin
        txd_d = (sub == 8'd6) ? 8'hD5 : 8'h55;
        en_d  = 1'b1;
      end
      PAYLOAD:
        if (s_axis.tvalid) begin
          txd_d   = s_axis.tdata;
          en_d    = 1'b1;
          er_d    = s_axis.tlast && s_axis.tuser;
          crc_upd = 1'b1;
        end else begin
          en_d  = 1'b1;
          er_d  = 1'b1;
          unf_d = 1'b1;
        end
      PAD: begin
        en_d    = 1'b1;
        crc_upd = 1'b1;
        crc_in  = 8'h00;
      end
      FCS: begin
        en_d = 1'b1;
        unique case (sub[1:0])
          2'd0: txd_d = ~crc[7:0];
          2'd1: txd_d = ~crc[15:8];
          2'd2: txd_d = ~crc[23:16];
          2'd3: txd_d = ~crc[31:24];
        endcase
      end
      default: ;
    endcase
  end

  // Sub-state counter, byte count, gap length, CRC
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      sub     <= '0;
      cnt     <= '0;
      ifg_len <= '0;
      crc     <= '0;
    end else begin
      sub <= (state_nxt != state) ? 8'd0
                                  : sub + 8'd1;
      if (state == IDLE)  cnt <= '0;
      else if (crc_upd)   cnt <= cnt_inc;
      if (state_nxt == IFG && state != IFG)
        ifg_len <= ifg_sel;
      if (state == IDLE || state == PREAMBLE)
        crc <= '1;
      else if (crc_upd)
        crc <= crc_step(crc, crc_in);
    end
  end

  // Registered GMII outputs and underflow pulse
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      gmii_txd        <= '0;
      gmii_tx_en      <= 1'b0;
      gmii_tx_er      <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      gmii_txd        <= txd_d;
      gmii_tx_en      <= en_d;
      gmii_tx_er      <= er_d;
      error_underflow <= unf_d;
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for the GMII framer: framing,
// CRC, padding, IFG, underflow and reset.
`timescale 1ns/1ps
module tb_gmii_frame_tx;
  logic       tx_clk = 1'b0;
  logic       tx_rst = 1'b1;
  logic [7:0] ifg_delay = 8'd0;

  gmii_frame_tx_if a0 ();
  gmii_frame_tx_if a1 ();

  logic [7:0] txd0, txd1;
  logic       en0, en1, er0, er1, uf0, uf1;

  logic       sel = 1'b0;
  logic [7:0] dd = 8'h00;
  logic       dv = 1'b0, dl = 1'b0, du = 1'b0;

  assign a0.tdata  = dd;
  assign a0.tvalid = dv & ~sel;
  assign a0.tlast  = dl;
  assign a0.tuser  = du;
  assign a1.tdata  = dd;
  assign a1.tvalid = dv & sel;
  assign a1.tlast  = dl;
  assign a1.tuser  = du;

  wire       rdy = sel ? a1.tready : a0.tready;
  wire [7:0] txd = sel ? txd1 : txd0;
  wire       en  = sel ? en1 : en0;
  wire       er  = sel ? er1 : er0;
  wire       uf  = sel ? uf1 : uf0;

  gmii_frame_tx u0 (
    .tx_clk          (tx_clk),
    .tx_rst          (tx_rst),
    .s_axis          (a0),
    .gmii_txd        (txd0),
    .gmii_tx_en      (en0),
    .gmii_tx_er      (er0),
    .ifg_delay       (ifg_delay),
    .error_underflow (uf0)
  );

  gmii_frame_tx #(.ENABLE_PADDING(0)) u1 (
    .tx_clk          (tx_clk),
    .tx_rst          (tx_rst),
    .s_axis          (a1),
    .gmii_txd        (txd1),
    .gmii_tx_en      (en1),
    .gmii_tx_er      (er1),
    .ifg_delay       (ifg_delay),
    .error_underflow (uf1)
  );

  always #4 tx_clk = ~tx_clk;

  int cyc = 0;
  always @(posedge tx_clk) cyc <= cyc + 1;

  logic [7:0] m_d  [0:8191];
  logic       m_en [0:8191];
  logic       m_er [0:8191];
  logic       m_uf [0:8191];

  always @(negedge tx_clk)
    if (cyc < 8192) begin
      m_d[cyc]  <= txd;
      m_en[cyc] <= en;
      m_er[cyc] <= er;
      m_uf[cyc] <= uf;
    end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320)
               : (r >> 1);
    return r;
  endfunction

  function automatic int find_en(input int from);
    for (int i = from; i < cyc && i < 8192; i++)
      if (m_en[i]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int s);
    int n = 0;
    while (s + n < cyc && s + n < 8192 &&
           m_en[s + n])
      n++;
    return n;
  endfunction

  logic [7:0] fb [0:255];
  int tv_cyc = 0;
  int acc_cyc = 0;

  task automatic send_frame(input string tag,
                            input int len,
                            input bit bad,
                            input int stall_at,
                            input int stop_at);
    int i = 0;
    int g = 0;
    bit st = 1'b0;
    while (i < stop_at && g < 3000) begin
      @(negedge tx_clk);
      g++;
      if (g == 1) tv_cyc = cyc;
      if (i == stall_at && !st) begin
        dv = 1'b0;
        st = 1'b1;
      end else begin
        dv = 1'b1;
        dd = fb[i];
        dl = (i == len - 1);
        du = bad && (i == len - 1);
        if (rdy) begin
          i++;
          acc_cyc = cyc;
        end
      end
    end
    chk({tag, "_accepted"}, i, stop_at);
  endtask

  task automatic idle(input int n);
    @(negedge tx_clk);
    dv = 1'b0;
    dl = 1'b0;
    du = 1'b0;
    repeat (n) @(negedge tx_clk);
  endtask

  task automatic check_frame(input string tag,
                             input int len,
                             input bit pad,
                             input int from,
                             input int exp_st,
                             output int st,
                             output logic [31:0] fcs);
    int s, n, nb, bad, ers;
    logic [31:0] c;
    logic [7:0]  e;
    nb = (pad && len < 60) ? 60 : len;
    s = find_en(from);
    chk({tag, "_start"}, s, exp_st);
    if (s < 0) s = 0;
    n = run_len(s);
    chk({tag, "_en_cycles"}, n, 12 + nb);
    c = '1;
    bad = 0;
    ers = 0;
    for (int k = 0; k < 8 + nb; k++) begin
      if (k < 7)            e = 8'h55;
      else if (k == 7)      e = 8'hD5;
      else if (k - 8 < len) e = fb[k - 8];
      else                  e = 8'h00;
      if (k >= 8) c = crc8(c, e);
      if (m_d[s + k] !== e) bad++;
    end
    for (int k = 0; k < n; k++)
      if (m_er[s + k]) ers++;
    fcs = {m_d[s + nb + 11], m_d[s + nb + 10],
           m_d[s + nb + 9],  m_d[s + nb + 8]};
    chk({tag, "_bad_bytes"}, bad, 0);
    chk({tag, "_fcs"}, fcs, ~c);
    chk({tag, "_er_count"}, ers, 0);
    st = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n, a, tv, ta, sa, sb, sc, cu, ce;
    logic [31:0] f;

    for (int k = 0; k < 256; k++)
      fb[k] = 8'(k * 37 + 11);

    repeat (3) @(negedge tx_clk);
    chk("rst_txd", txd, 8'h00);
    chk("rst_en", en, 1'b0);
    chk("rst_er", er, 1'b0);
    chk("rst_tready", rdy, 1'b0);
    chk("rst_underflow", uf, 1'b0);
    tx_rst = 1'b0;
    repeat (3) @(negedge tx_clk);

    // minimum frame, padded
    fb[0] = 8'hAB;
    send_frame("min", 1, 1'b0, -1, 1);
    tv = tv_cyc;
    idle(90);
    check_frame("min", 1, 1'b1, tv, tv + 1, s, f);
    chk("min_payload", m_d[s + 8], 8'hAB);

    // CRC check value, no padding
    sel = 1'b1;
    for (int k = 0; k < 9; k++)
      fb[k] = 8'(8'h31 + k);
    send_frame("crc", 9, 1'b0, -1, 9);
    tv = tv_cyc;
    idle(30);
    check_frame("crc", 9, 1'b0, tv, tv + 1, s, f);
    chk("crc_check_value", f, 32'hCBF43926);
    sel = 1'b0;
    for (int k = 0; k < 256; k++)
      fb[k] = 8'(k * 37 + 11);

    // long frame, no pad
    send_frame("long", 100, 1'b0, -1, 100);
    tv = tv_cyc;
    idle(130);
    check_frame("long", 100, 1'b1, tv, tv + 1, s, f);
    chk("long_first_byte", m_d[tv + 9], fb[0]);

    // underflow after 10 bytes, then next frame
    send_frame("unf", 20, 1'b0, 10, 20);
    tv = tv_cyc;
    a = acc_cyc;
    send_frame("unf_next", 8, 1'b0, -1, 8);
    idle(90);
    s = find_en(tv);
    chk("unf_start", s, tv + 1);
    if (s < 0) s = 0;
    n = run_len(s);
    chk("unf_en_cycles", n, 19);
    chk("unf_byte", m_d[s + 18], 8'h00);
    chk("unf_er", m_er[s + 18], 1'b1);
    chk("unf_pulse_align", m_uf[s + 18], 1'b1);
    cu = 0;
    ce = 0;
    for (int k = s; k <= a + 1; k++) begin
      if (m_uf[k]) cu++;
      if (m_er[k]) ce++;
    end
    chk("unf_pulse_count", cu, 1);
    chk("unf_er_count", ce, 1);
    check_frame("unf_next", 8, 1'b1, s + 19,
                a + 14, sa, f);

    // IFG enforcement and bad-frame marker
    ifg_delay = 8'd5;
    send_frame("ifg_a", 10, 1'b0, -1, 10);
    ta = tv_cyc;
    send_frame("ifg_b", 10, 1'b0, -1, 10);
    ifg_delay = 8'd20;
    send_frame("ifg_c", 10, 1'b0, -1, 10);
    send_frame("bad", 5, 1'b1, -1, 5);
    idle(120);
    check_frame("ifg_a", 10, 1'b1, ta, ta + 1, sa, f);
    check_frame("ifg_b", 10, 1'b1, sa + 72,
                sa + 72 + 12, sb, f);
    check_frame("ifg_c", 10, 1'b1, sb + 72,
                sb + 72 + 20, sc, f);
    s = find_en(sc + 72);
    chk("bad_start", s, sc + 72 + 20);
    if (s < 0) s = 0;
    n = run_len(s);
    chk("bad_en_cycles", n, 13);
    chk("bad_last_er", m_er[s + 12], 1'b1);
    chk("bad_last_byte", m_d[s + 12], fb[4]);
    ce = 0;
    for (int k = s; k < s + 20; k++)
      if (m_er[k]) ce++;
    chk("bad_er_count", ce, 1);

    // asynchronous reset in mid-payload
    send_frame("rst", 40, 1'b0, -1, 20);
    @(negedge tx_clk);
    chk("rst_mid_en_before", en, 1'b1);
    tx_rst = 1'b1;
    #1;
    chk("rst_mid_txd", txd, 8'h00);
    chk("rst_mid_en", en, 1'b0);
    chk("rst_mid_er", er, 1'b0);
    chk("rst_mid_tready", rdy, 1'b0);
    dv = 1'b0;
    dl = 1'b0;
    repeat (2) @(negedge tx_clk);
    tx_rst = 1'b0;
    idle(5);
    send_frame("post", 30, 1'b0, -1, 30);
    tv = tv_cyc;
    idle(110);
    check_frame("post", 30, 1'b1, tv, tv + 1, s, f);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
